// File: rtl/ctl_seq_pkg.sv
// Shared definitions for the control sequencer: state encoding and the
// channel-index width derivation.
package ctl_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    GO   = 2'd1,
    DONE = 2'd2
  } state_t;

  // Channel index width; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ctl_seq_cnt.sv
// Run-length down-counter: synchronous load, decrement that stops at zero,
// and a zero flag.
module ctl_seq_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ctl_seq.sv
// Parametrised control sequencer: strobes each channel in turn for len cycles,
// then reports completion as a pulse or an ack-released hold.
module ctl_seq
  import ctl_seq_pkg::*;
#(
  parameter  int N_CH      = 1,
  parameter  int CNT_W     = 8,
  parameter  int DONE_HOLD = 0,
  localparam int CH_W      = ch_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  input  logic             ack,
  output logic [N_CH-1:0]  ctl,
  output logic [CH_W-1:0]  ch,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] len_q;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             ch_clr, ch_inc, err_clr, err_set, len_cap;

  ctl_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len_q <= '0;
      ch    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (len_cap) len_q <= len;
      if (ch_clr) ch <= '0;
      else if (ch_inc) ch <= ch + CH_W'(1);
      if (err_clr) err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    ch_clr   = 1'b0;
    ch_inc   = 1'b0;
    err_clr  = 1'b0;
    err_set  = 1'b0;
    len_cap  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          len_cap = 1'b1;
          ch_clr  = 1'b1;
          err_clr = 1'b1;
          if (len != '0) begin
            cnt_load = 1'b1;
            cnt_val  = len - CNT_W'(1);
            state_nx = GO;
          end else begin
            state_nx = DONE;
          end
        end
      end
      GO: begin
        // abort outranks the count/channel advance in the same cycle
        if (abort) begin
          err_set  = 1'b1;
          state_nx = DONE;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (ch < CH_LAST) begin
          ch_inc   = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = len_q - CNT_W'(1);
        end else begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if ((DONE_HOLD == 0) || ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ctl = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      ctl[i] = (state == GO) && (ch == CH_W'(i));
    end
  end

  assign busy = (state == GO) || (state == DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_ctl_seq.sv
// Self-checking bench for ctl_seq: a 4-channel pulse-mode instance and a
// 1-channel hold-mode instance, checked cycle by cycle against a scoreboard.
module tb_ctl_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, abort_a = 1'b0, ack_a = 1'b0;
  logic [7:0] len_a = '0;
  logic [3:0] ctl_a;
  logic [1:0] ch_a;
  logic       busy_a, done_a, err_a;
  logic       start_b = 1'b0, abort_b = 1'b0, ack_b = 1'b0;
  logic [7:0] len_b = '0;
  logic       ctl_b, ch_b, busy_b, done_b, err_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       sel;
    logic [3:0] ctl;
    logic [1:0] ch;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ctl_seq #(.N_CH(4), .CNT_W(8), .DONE_HOLD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .len(len_a), .abort(abort_a),
    .ack(ack_a), .ctl(ctl_a), .ch(ch_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  ctl_seq #(.N_CH(1), .CNT_W(8), .DONE_HOLD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .len(len_b), .abort(abort_b),
    .ack(ack_b), .ctl(ctl_b), .ch(ch_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic sel, input logic [3:0] c, input logic [1:0] h,
                      input logic b, input logic d, input logic e);
    exp_t x;
    x.sel = sel; x.ctl = c; x.ch = h; x.busy = b; x.done = d; x.err = e;
    sb.push_back(x);
  endtask

  // One clock; if an expectation is pending, compare it against the DUT it names.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.sel) begin
        chk("a_ctl",  32'(ctl_a),  32'(e.ctl));
        chk("a_ch",   32'(ch_a),   32'(e.ch));
        chk("a_busy", 32'(busy_a), 32'(e.busy));
        chk("a_done", 32'(done_a), 32'(e.done));
        chk("a_err",  32'(err_a),  32'(e.err));
      end else begin
        chk("b_ctl",  32'(ctl_b),  32'(e.ctl));
        chk("b_ch",   32'(ch_b),   32'(e.ch));
        chk("b_busy", 32'(busy_b), 32'(e.busy));
        chk("b_done", 32'(done_b), 32'(e.done));
        chk("b_err",  32'(err_b),  32'(e.err));
      end
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) tick();
  endtask

  // Full sequence on the 4-channel instance: N_CH*len GO cycles, one DONE, then IDLE.
  task automatic run_a(input int l);
    logic [1:0] last_ch;
    start_a = 1'b1;
    len_a   = 8'(l);
    if (l == 0) begin
      push(1'b0, 4'h0, 2'd0, 1'b1, 1'b1, 1'b0);
      last_ch = 2'd0;
    end else begin
      for (int c = 0; c < 4 * l; c++)
        push(1'b0, 4'(1 << (c / l)), 2'(c / l), 1'b1, 1'b0, 1'b0);
      push(1'b0, 4'h0, 2'd3, 1'b1, 1'b1, 1'b0);
      last_ch = 2'd3;
    end
    push(1'b0, 4'h0, last_ch, 1'b0, 1'b0, 1'b0);
    tick();
    start_a = 1'b0;
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_ctl",  32'({ctl_b, ctl_a}), 32'h0);
    chk("rst_ch",   32'({ch_b, ch_a}),   32'h0);
    chk("rst_busy", 32'({busy_b, busy_a}), 32'h0);
    chk("rst_done", 32'({done_b, done_a}), 32'h0);
    chk("rst_err",  32'({err_b, err_a}),   32'h0);
    #10 rst_n = 1'b1;

    run_a(2);
    run_a(3);
    run_a(0);

    // abort in IDLE is ignored
    abort_a = 1'b1;
    push(1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    abort_a = 1'b0;

    // abort sampled at the end of GO cycle 2, len=5
    start_a = 1'b1;
    len_a   = 8'd5;
    for (int c = 0; c < 3; c++) push(1'b0, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    start_a = 1'b0;
    tick();
    tick();
    abort_a = 1'b1;
    push(1'b0, 4'h0, 2'd0, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) push(1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    abort_a = 1'b0;
    drain();
    run_a(1);

    run_a(255);

    // asynchronous reset in the middle of GO
    start_a = 1'b1;
    len_a   = 8'd5;
    push(1'b0, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0);
    push(1'b0, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    start_a = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl",  32'(ctl_a),  32'h0);
    chk("arst_busy", 32'(busy_a), 32'h0);
    chk("arst_done", 32'(done_a), 32'h0);
    chk("arst_ch",   32'(ch_a),   32'h0);
    #2 rst_n = 1'b1;
    run_a(2);

    // hold mode: ack ignored in GO, start ignored in DONE, release on ack
    start_b = 1'b1;
    len_b   = 8'd3;
    ack_b   = 1'b1;
    for (int c = 0; c < 3; c++) push(1'b1, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) push(1'b1, 4'h0, 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    start_b = 1'b0;
    tick();
    tick();
    ack_b   = 1'b0;
    start_b = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    start_b = 1'b0;
    ack_b   = 1'b1;
    push(1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    ack_b = 1'b0;
    push(1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
